// File: rtl/arb_requester_if.sv
// Request/grant bundle between the local job sources, the requester engine and the shared arbiter.
interface arb_requester_if #(
  parameter int unsigned LEN_W = 4
);
  logic [1:0]         job_valid;
  logic [2*LEN_W-1:0] job_len;
  logic [1:0]         job_ready;
  logic [1:0]         request;
  logic [1:0]         grant;
  logic [1:0]         beat;
  logic [1:0]         done;
  logic [1:0]         starve;
  logic               proto_err;
  logic               clr_err;

  modport master (
    input  job_valid, job_len, grant, clr_err,
    output job_ready, request, beat, done, starve, proto_err
  );

  modport slave (
    output job_valid, job_len, grant, clr_err,
    input  job_ready, request, beat, done, starve, proto_err
  );
endinterface

// File: rtl/arb_requester.sv
// Two-channel requester engine: takes N-beat jobs, requests the arbiter, beats while granted,
// and watches the grant side for starvation and protocol violations.
module arb_requester #(
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 200
) (
  input  logic            clk,
  input  logic            reset,
  arb_requester_if.master bus
);
  localparam int unsigned NCH = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY} state_e;

  state_e            state_q [NCH];
  state_e            state_d [NCH];
  logic [LEN_W-1:0]  rem_q   [NCH];
  logic [LEN_W-1:0]  rem_d   [NCH];
  logic [LEN_W-1:0]  len_c   [NCH];
  logic [WAIT_W-1:0] wait_q  [NCH];
  logic [WAIT_W-1:0] wait_d  [NCH];
  logic [NCH-1:0]    done_q, done_d;
  logic [NCH-1:0]    starve_q, starve_d;
  logic [NCH-1:0]    req_c, beat_c, reach_c;
  logic              proto_q, proto_d;

  // Per-channel next state, beat/wait bookkeeping and sticky error flags
  always_comb begin
    req_c   = '0;
    beat_c  = '0;
    reach_c = '0;
    done_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      wait_d[i]  = wait_q[i];
      len_c[i]   = bus.job_len[i*LEN_W +: LEN_W];
      req_c[i]   = (state_q[i] != ST_IDLE);
      beat_c[i]  = (state_q[i] == ST_BUSY) && bus.grant[i];

      unique case (state_q[i])
        ST_IDLE: begin
          if (bus.job_valid[i]) begin
            state_d[i] = ST_REQ;
            rem_d[i]   = (len_c[i] == '0) ? LEN_W'(1) : len_c[i];
          end
        end
        ST_REQ: begin
          if (bus.grant[i]) state_d[i] = ST_BUSY;
        end
        ST_BUSY: begin
          if (beat_c[i]) begin
            if (rem_q[i] == LEN_W'(1)) begin
              state_d[i] = ST_IDLE;
              done_d[i]  = 1'b1;
            end else begin
              rem_d[i] = rem_q[i] - LEN_W'(1);
            end
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase

      // Starvation counter: runs while requesting without grant, saturates at the limit
      if (!req_c[i] || beat_c[i]) begin
        wait_d[i] = '0;
      end else if (!bus.grant[i]) begin
        wait_d[i]  = (wait_q[i] == WAIT_W'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
        reach_c[i] = (wait_d[i] == WAIT_W'(MAX_WAIT));
      end
    end

    // A fresh violation in the clear cycle keeps the flag set
    starve_d = (starve_q & ~{NCH{bus.clr_err}}) | reach_c;
    proto_d  = (proto_q & ~bus.clr_err) | (|(bus.grant & ~req_c)) | (&bus.grant);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        rem_q[i]   <= '0;
        wait_q[i]  <= '0;
      end
      done_q   <= '0;
      starve_q <= '0;
      proto_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
        wait_q[i]  <= wait_d[i];
      end
      done_q   <= done_d;
      starve_q <= starve_d;
      proto_q  <= proto_d;
    end
  end

  assign bus.request   = req_c;
  assign bus.job_ready = ~req_c;
  assign bus.beat      = beat_c;
  assign bus.done      = done_q;
  assign bus.starve    = starve_q;
  assign bus.proto_err = proto_q;
endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios plus randomized traffic against a job-level model.
module tb_arb_requester;
  localparam int unsigned LEN_W = 4;
  localparam int MAXW = 5;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  arb_requester_if #(.LEN_W(LEN_W)) bus();

  arb_requester #(.LEN_W(LEN_W), .WAIT_W(8), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Job-level model: a channel is either holding a job or not; a job is first granted, then drains beats
  bit [1:0] m_active, m_granted, m_done, m_starve, m_beat;
  int       m_rem  [2];
  int       m_wait [2];
  bit       m_perr;

  logic [1:0] cur_jv, cur_g;
  logic [7:0] cur_jl;
  logic       cur_clr;
  logic [10:0] exp_v, act_v;

  task automatic model_clear();
    m_active = '0; m_granted = '0; m_done = '0; m_starve = '0; m_perr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0;
      m_wait[i] = 0;
    end
  endtask

  task automatic drive(input logic [1:0] jv, input logic [7:0] jl, input logic [1:0] g, input logic clr);
    cur_jv = jv; cur_jl = jl; cur_g = g; cur_clr = clr;
    bus.job_valid = jv; bus.job_len = jl; bus.grant = g; bus.clr_err = clr;
    #1;
    for (int i = 0; i < 2; i++) m_beat[i] = m_active[i] & m_granted[i] & g[i];
    exp_v = {m_active, m_beat, m_done, ~m_active, m_starve, m_perr};
    act_v = {bus.request, bus.beat, bus.done, bus.job_ready, bus.starve, bus.proto_err};
  endtask

  task automatic tick();
    bit [1:0] nd = '0;
    bit [1:0] reach = '0;
    bit viol;
    viol = ((cur_g & ~m_active) != 2'b00) || (cur_g == 2'b11);
    for (int i = 0; i < 2; i++) begin
      bit starving = 1'b0;
      if (!m_active[i]) begin
        m_wait[i] = 0;
        if (cur_jv[i]) begin
          int len;
          len = int'((cur_jl >> (4 * i)) & 8'h0f);
          m_active[i]  = 1'b1;
          m_granted[i] = 1'b0;
          m_rem[i]     = (len == 0) ? 1 : len;
        end
      end else if (!m_granted[i]) begin
        if (cur_g[i]) m_granted[i] = 1'b1;
        else starving = 1'b1;
      end else if (cur_g[i]) begin
        m_wait[i] = 0;
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_active[i] = 1'b0;
          nd[i] = 1'b1;
        end
      end else begin
        starving = 1'b1;
      end
      if (starving) begin
        m_wait[i] = (m_wait[i] < MAXW) ? m_wait[i] + 1 : MAXW;
        if (m_wait[i] == MAXW) reach[i] = 1'b1;
      end
    end
    m_done   = nd;
    m_starve = (cur_clr ? 2'b00 : m_starve) | reach;
    m_perr   = (m_perr && !cur_clr) || viol;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    drive(2'b00, 8'h00, 2'b00, 1'b0);
    checks++;
    if (act_v !== 11'b00_00_00_11_00_0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", act_v, 11'b00_00_00_11_00_0);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int nbeats = 0, first_beat = -1, done_cyc = -1;
    logic req1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive((c == 0) ? 2'b01 : 2'b00, 8'h03, m_active, 1'b0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      if (bus.beat[0]) begin
        nbeats++;
        if (first_beat < 0) first_beat = c;
      end
      if (bus.done[0] && done_cyc < 0) done_cyc = c;
      if (c == 1) req1 = bus.request[0];
      tick();
    end
    checks++;
    if (nbeats != 3 || first_beat != 2 || done_cyc != 5 || req1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_timing beats=%0d first=%0d done=%0d req1=%b exp 3/2/5/1", nbeats, first_beat, done_cyc, req1);
    end
  endtask

  task automatic test_grant_pause();
    int nbeats = 0, pause = 0, last_beat = -1, done_cyc = -1;
    logic [1:0] g;
    for (int c = 0; c < 12; c++) begin
      g = m_active;
      if (nbeats == 2 && pause < 2) begin
        g = 2'b00;
        pause++;
      end
      drive((c == 0) ? 2'b01 : 2'b00, 8'h04, g, 1'b0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL pause cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      if (bus.beat[0]) begin
        nbeats++;
        last_beat = c;
      end
      if (bus.done[0] && done_cyc < 0) done_cyc = c;
      tick();
    end
    checks++;
    if (nbeats != 4 || done_cyc != last_beat + 1 || done_cyc != 8) begin
      errors++;
      $display("FAIL pause_count beats=%0d last=%0d done=%0d exp 4/7/8", nbeats, last_beat, done_cyc);
    end
  endtask

  task automatic test_two_channels();
    int done0 = -1, done1 = -1, overlap = 0, nbeats = 0;
    logic [1:0] g;
    for (int c = 0; c < 10; c++) begin
      g = m_active[1] ? 2'b10 : (m_active[0] ? 2'b01 : 2'b00);
      drive((c == 0) ? 2'b11 : 2'b00, 8'h22, g, 1'b0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL two_ch cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      if (bus.beat == 2'b11) overlap++;
      if (bus.done[0] && done0 < 0) done0 = c;
      if (bus.done[1] && done1 < 0) done1 = c;
      tick();
    end
    checks++;
    if (overlap != 0 || done1 != 4 || done0 != 7 || bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL two_ch_order overlap=%0d done1=%0d done0=%0d perr=%b exp 0/4/7/0", overlap, done1, done0, bus.proto_err);
    end
    for (int c = 0; c < 6; c++) begin
      drive((c == 0) ? 2'b01 : 2'b00, 8'h00, m_active, 1'b0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL zero_len cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      if (bus.beat[0]) nbeats++;
      tick();
    end
    checks++;
    if (nbeats != 1) begin
      errors++;
      $display("FAIL zero_len_beats got=%0d exp=1", nbeats);
    end
  endtask

  task automatic test_proto();
    logic [1:0] g_seq   [6] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00};
    logic       clr_seq [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
    logic       exp_p   [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int c = 0; c < 6; c++) begin
      drive(2'b00, 8'h00, g_seq[c], clr_seq[c]);
      checks++;
      if (act_v !== exp_v || bus.proto_err !== exp_p[c]) begin
        errors++;
        $display("FAIL proto cyc=%0d got=%b exp=%b perr=%b want=%b", c, act_v, exp_v, bus.proto_err, exp_p[c]);
      end
      tick();
    end
  endtask

  task automatic test_starve();
    logic [1:0] g;
    logic       clr;
    for (int c = 0; c < 14; c++) begin
      g   = (c >= 8) ? m_active : 2'b00;
      clr = (c == 12);
      drive((c == 0) ? 2'b01 : 2'b00, 8'h02, g, clr);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL starve cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      if ((c == 5 && bus.starve[0] !== 1'b0) || ((c == 6 || c == 11 || c == 12) && bus.starve[0] !== 1'b1)
          || (c == 13 && bus.starve[0] !== 1'b0)) begin
        errors++;
        $display("FAIL starve_flag cyc=%0d got=%b", c, bus.starve[0]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      drive((c == 0) ? 2'b01 : 2'b00, 8'h04, m_active, 1'b0);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      if (c < 3) tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.request, bus.beat, bus.done, bus.job_ready} !== 8'b00_00_00_11) begin
      errors++;
      $display("FAIL rst_mid_async got=%b exp=%b", {bus.request, bus.beat, bus.done, bus.job_ready}, 8'b00_00_00_11);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(2'b00, 8'h00, 2'b00, 1'b0);
      checks++;
      if (act_v !== exp_v || bus.job_ready !== 2'b11) begin
        errors++;
        $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [1:0] g, jv;
    logic [7:0] jl;
    logic       clr;
    int         r;
    for (int c = 0; c < 400; c++) begin
      jv  = 2'($urandom_range(0, 3));
      jl  = 8'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      r   = int'($urandom_range(0, 9));
      if (r < 7) begin
        if (m_active == 2'b11) g = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        else g = m_active;
      end else if (r == 8) begin
        g = 2'($urandom_range(0, 3));
      end else begin
        g = 2'b00;
      end
      drive(jv, jl, g, clr);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", c, act_v, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.job_valid = '0;
    bus.job_len   = '0;
    bus.grant     = '0;
    bus.clr_err   = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_grant_pause();
    test_two_channels();
    test_proto();
    test_starve();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
